b_resp_arbiter: RTL and testbench
=================================

// Module: b_resp_arbiter
// PURPOSE
//  Round-robin arbiter that merges B-channel responses queued in NUM_SRC response
//  FIFOs into one AXI B channel toward a master port of the crossbar. Each source
//  FIFO exposes front_BID/front_BRESP/empty and accepts a pop pulse.
//  The block owns a registered B output stage, sustains one response per cycle and
//  holds BID/BRESP stable under back-pressure.
// PARAMETERS
//  ID_WIDTH   4   width of BID
//  NUM_SRC    4   number of source response FIFOs (>=2)
// PORTS
//  ACLK        in   1                 clock; all logic on posedge
//  ARESETn     in   1                 synchronous, active-low reset
//  src_empty   in   NUM_SRC           bit i = FIFO i empty
//  src_BID     in   NUM_SRC*ID_WIDTH  FIFO i front BID at [i*ID_WIDTH +: ID_WIDTH]
//  src_BRESP   in   NUM_SRC*2         FIFO i front BRESP at [i*2 +: 2]
//  src_pop     out  NUM_SRC           one-hot pop pulse to FIFO i
//  BID         out  ID_WIDTH          response ID to master
//  BRESP       out  2                 response code to master
//  BVALID      out  1                 response valid
//  BREADY      in   1                 master accepts response
//  grant_idx   out  $clog2(NUM_SRC)   source of the response in the output stage
// BEHAVIOUR
//  - Reset (ARESETn=0 at posedge): BVALID=0, BID=0, BRESP=0, grant_idx=0,
//    last_grant=NUM_SRC-1 (so source 0 has top priority first), state=IDLE.
//    src_pop is forced 0 while ARESETn=0.
//  - Output stage is free when BVALID=0 or (BVALID & BREADY).
//  - load = stage free & |(~src_empty). Winner = first non-empty source at or after
//    (last_grant+1) mod NUM_SRC, wrapping NUM_SRC-1 -> 0.
//  - On load (combinational in cycle N): src_pop[winner]=1 for exactly that cycle;
//    other bits 0. At posedge ending N: BID/BRESP <= winner front, grant_idx and
//    last_grant <= winner, BVALID <= 1.
//  - Latency: FIFO non-empty with stage free in cycle N -> BVALID=1 in cycle N+1.
//  - Stage free but all sources empty: BVALID <= 0, BID/BRESP/grant_idx hold.
//  - FSM: IDLE (BVALID=0) -> HOLD on load. HOLD & ~BREADY: stay; BID/BRESP/
//    grant_idx must not change; no pop. HOLD & BREADY & load: stay HOLD, new
//    response loaded (back-to-back, 1 resp/cycle). HOLD & BREADY & ~load -> IDLE.
//  - At most one src_pop bit per cycle; never pop a source whose src_empty=1.
//  - The same source may win consecutive cycles only if it is the only non-empty one.
//  - The source FIFO advances front/empty on the posedge after pop; the arbiter relies
//    on that, and the next cycle's src_empty/src_BID already reflect the pop.
//  - Reset mid-operation: a response held in the stage (already popped) is discarded;
//    BVALID is 0 in the first cycle after reset and no pop occurs during reset.
//  - BREADY while BVALID=0 is ignored.
//  - Arithmetic: last_grant+1 computed modulo NUM_SRC (not 2^width) for non-power-of-2 NUM_SRC.
// TESTING
//  1 Single: reset; src_empty=4'b1101, src1 BID=3 BRESP=0, BREADY=1 -> src_pop=4'b0010
//    at N; BVALID=1 BID=3 BRESP=0 grant_idx=1 at N+1.
//  2 Rotation: all four non-empty, BREADY=1 held -> grant order 0,1,2,3,0; one pop/cycle,
//    BVALID continuous.
//  3 Back-pressure: BVALID=1 BID=5 BRESP=2'b10, BREADY=0 for 6 cycles with other
//    sources non-empty -> BID/BRESP/grant_idx stable, src_pop=0; BREADY=1 -> next
//    source loaded the following cycle.
//  4 Wrap/skip: last_grant=2, only src1 non-empty -> grant 1 (wrap through 3,0).
//    NUM_SRC=3 build: last_grant=2 -> next candidate is 0.
//  5 Drain: single source holding 2 entries, BREADY=1 -> two BVALID cycles, then
//    BVALID=0 once src_empty=1; no pop while empty.
//  6 Reset mid-op: ARESETn=0 during HOLD with BREADY=0 -> next cycle BVALID=0 BID=0,
//    src_pop=0; after release src0 wins first.

Source files
------------

// File: rtl/b_resp_arbiter.sv
// b_resp_arbiter: round-robin merge of NUM_SRC B-response FIFOs into one
// registered AXI B channel. One response per cycle; BID/BRESP/grant_idx are
// frozen while BVALID is asserted and BREADY is low.
module b_resp_arbiter #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_SRC  = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [NUM_SRC-1:0]          src_empty,
  input  logic [NUM_SRC*ID_WIDTH-1:0] src_BID,
  input  logic [NUM_SRC*2-1:0]        src_BRESP,
  output logic [NUM_SRC-1:0]          src_pop,
  output logic [ID_WIDTH-1:0]         BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [$clog2(NUM_SRC)-1:0]  grant_idx
);

  localparam int GW = $clog2(NUM_SRC);
  // Source count at candidate width (one bit wider than an index so that
  // last_grant + offset never overflows before the modulo correction).
  localparam logic [GW:0] NSRC = (GW+1)'(NUM_SRC);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t              r_state;
  logic                r_bvalid;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]          r_bresp;
  logic [GW-1:0]       r_grant_idx;
  logic [GW-1:0]       r_last_grant;

  logic [ID_WIDTH-1:0] w_bid_arr   [NUM_SRC];
  logic [1:0]          w_bresp_arr [NUM_SRC];
  logic [GW-1:0]       w_winner;
  logic [GW:0]         w_cand;
  logic                w_found;
  logic                w_free;
  logic                w_load;

  // Unpack the flattened FIFO fronts and build the one-hot pop. Pop is gated
  // by reset so nothing is consumed while the stage is being cleared.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_bid_arr[gi]   = src_BID[gi*ID_WIDTH +: ID_WIDTH];
    assign w_bresp_arr[gi] = src_BRESP[gi*2 +: 2];
    assign src_pop[gi]     = ARESETn & w_load & (w_winner == GW'(gi));
  end

  // Round-robin search: first non-empty source starting one past last_grant,
  // wrapping modulo NUM_SRC (works for non-power-of-two source counts).
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_cand >= NSRC) begin
        w_cand = w_cand - NSRC;
      end
      if (!w_found && !src_empty[w_cand[GW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[GW-1:0];
      end
    end
  end

  // Stage accepts a new response when empty or being drained this cycle.
  always_comb begin
    w_free = ~r_bvalid | BREADY;
    w_load = w_free & w_found;
  end

  // Output-stage FSM: IDLE holds nothing, HOLD presents a response until
  // accepted; a load on acceptance keeps HOLD for back-to-back traffic.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state      <= IDLE;
      r_bvalid     <= 1'b0;
      r_bid        <= '0;
      r_bresp      <= '0;
      r_grant_idx  <= '0;
      r_last_grant <= GW'(NUM_SRC - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state      <= HOLD;
            r_bvalid     <= 1'b1;
            r_bid        <= w_bid_arr[w_winner];
            r_bresp      <= w_bresp_arr[w_winner];
            r_grant_idx  <= w_winner;
            r_last_grant <= w_winner;
          end
        end
        HOLD: begin
          if (BREADY) begin
            if (w_load) begin
              r_bvalid     <= 1'b1;
              r_bid        <= w_bid_arr[w_winner];
              r_bresp      <= w_bresp_arr[w_winner];
              r_grant_idx  <= w_winner;
              r_last_grant <= w_winner;
            end else begin
              r_state  <= IDLE;
              r_bvalid <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_bvalid <= 1'b0;
        end
      endcase
    end
  end

  assign BVALID    = r_bvalid;
  assign BID       = r_bid;
  assign BRESP     = r_bresp;
  assign grant_idx = r_grant_idx;

endmodule

// File: tb/tb_b_resp_arbiter.sv
// Directed bench for b_resp_arbiter: a table of per-cycle vectors for the
// 4-source build plus short sequences for latency and a 3-source build.
module tb_b_resp_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  src_empty;
  logic [15:0] src_bid;
  logic [7:0]  src_bresp;
  logic [3:0]  src_pop;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  gidx;

  logic [2:0]  src_empty3;
  logic [11:0] src_bid3;
  logic [5:0]  src_bresp3;
  logic [2:0]  src_pop3;
  logic [3:0]  bid3;
  logic [1:0]  bresp3;
  logic        bvalid3;
  logic        bready3;
  logic [1:0]  gidx3;

  int n_checks;
  int n_errors;

  b_resp_arbiter #(.ID_WIDTH(4), .NUM_SRC(4)) u_dut (
    .ACLK(clk), .ARESETn(rst_n), .src_empty(src_empty), .src_BID(src_bid),
    .src_BRESP(src_bresp), .src_pop(src_pop), .BID(bid), .BRESP(bresp),
    .BVALID(bvalid), .BREADY(bready), .grant_idx(gidx)
  );

  b_resp_arbiter #(.ID_WIDTH(4), .NUM_SRC(3)) u_dut3 (
    .ACLK(clk), .ARESETn(rst_n), .src_empty(src_empty3), .src_BID(src_bid3),
    .src_BRESP(src_bresp3), .src_pop(src_pop3), .BID(bid3), .BRESP(bresp3),
    .BVALID(bvalid3), .BREADY(bready3), .grant_idx(gidx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] empty;
    logic       bready;
    logic [3:0] pop;
    logic       bvalid;
    logic [3:0] bid;
    logic [1:0] bresp;
    logic [1:0] gidx;
  } vec_t;

  vec_t vecs [33];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  // Drive one row just after a posedge, check at the following negedge.
  task automatic run_row(input vec_t v, input int row);
    rst_n     = v.rstn;
    src_empty = v.empty;
    bready    = v.bready;
    @(negedge clk);
    chk("src_pop",   row, 32'(src_pop), 32'(v.pop));
    chk("BVALID",    row, 32'(bvalid),  32'(v.bvalid));
    chk("BID",       row, 32'(bid),     32'(v.bid));
    chk("BRESP",     row, 32'(bresp),   32'(v.bresp));
    chk("grant_idx", row, 32'(gidx),    32'(v.gidx));
    $display("row %0d rstn=%b empty=%b bready=%b -> pop=%b bvalid=%b bid=%h bresp=%0d gidx=%0d",
             row, v.rstn, v.empty, v.bready, src_pop, bvalid, bid, bresp, gidx);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [2:0] exp_pop3 [5];
    logic [1:0] exp_g3   [5];
    logic [3:0] exp_b3   [5];

    n_checks = 0;
    n_errors = 0;

    // Fronts held constant: src0 A/OKAY, src1 3/OKAY, src2 5/SLVERR, src3 C/EXOKAY.
    src_bid    = 16'hC53A;
    src_bresp  = 8'b01_10_00_00;
    src_empty  = 4'b1111;
    bready     = 1'b0;
    src_bid3   = 12'h421;
    src_bresp3 = 6'b10_01_00;
    src_empty3 = 3'b111;
    bready3    = 1'b0;
    rst_n      = 1'b0;

    //          rstn  empty    brdy  pop      v     bid    resp  gidx
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0, 2'd0}; // reset state
    vecs[1]  = '{1'b1, 4'b1101, 1'b1, 4'b0010, 1'b0, 4'h0, 2'd0, 2'd0}; // single src1
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'h3, 2'd0, 2'd1};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd0, 2'd1};
    vecs[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd0, 2'd1}; // reset, pop gated
    vecs[5]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'h0, 2'd0, 2'd0}; // rotation
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd0, 2'd0};
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd0, 2'd1};
    vecs[8]  = '{1'b1, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'hC, 2'd1, 2'd3};
    vecs[10] = '{1'b1, 4'b0000, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd0, 2'd0};
    vecs[11] = '{1'b1, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd0, 2'd1};
    vecs[12] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2}; // back-pressure x6
    vecs[13] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[14] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[15] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[16] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[17] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2, 2'd2};
    vecs[18] = '{1'b1, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'h5, 2'd2, 2'd2}; // release
    vecs[19] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'hC, 2'd1, 2'd3};
    vecs[20] = '{1'b1, 4'b1011, 1'b1, 4'b0100, 1'b0, 4'hC, 2'd1, 2'd3}; // set last_grant=2
    vecs[21] = '{1'b1, 4'b1101, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd2, 2'd2}; // wrap to src1
    vecs[22] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'h3, 2'd0, 2'd1};
    vecs[23] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd0, 2'd1}; // BREADY while idle
    vecs[24] = '{1'b1, 4'b0111, 1'b1, 4'b1000, 1'b0, 4'h3, 2'd0, 2'd1}; // drain src3 x2
    vecs[25] = '{1'b1, 4'b0111, 1'b1, 4'b1000, 1'b1, 4'hC, 2'd1, 2'd3};
    vecs[26] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'hC, 2'd1, 2'd3};
    vecs[27] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd1, 2'd3};
    vecs[28] = '{1'b1, 4'b1110, 1'b0, 4'b0001, 1'b0, 4'hC, 2'd1, 2'd3}; // load src0
    vecs[29] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd0, 2'd0}; // holding
    vecs[30] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'hA, 2'd0, 2'd0}; // reset mid-op
    vecs[31] = '{1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'h0, 2'd0, 2'd0}; // src0 first
    vecs[32] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 4'hA, 2'd0, 2'd0};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 33; i++) begin
      run_row(vecs[i], i);
    end

    // Latency: stage idle, src2 alone becomes non-empty -> BVALID next cycle.
    src_empty = 4'b1011;
    bready    = 1'b1;
    @(negedge clk);
    chk("lat_pop", 0, 32'(src_pop), 32'h4);
    @(posedge clk);
    #1;
    src_empty = 4'b1111;
    lat = 1;
    while (!bvalid && lat < 5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat_cycles", 0, 32'(lat), 32'd1);
    chk("lat_bid", 0, 32'(bid), 32'h5);
    $display("latency seq: cycles=%0d bid=%h bresp=%0d gidx=%0d", lat, bid, bresp, gidx);

    // 3-source build: last_grant resets to 2, so order is 0,1,2,0,1.
    exp_pop3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    exp_g3   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    exp_b3   = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h1};
    src_empty3 = 3'b000;
    bready3    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("n3_pop", c, 32'(src_pop3), 32'(exp_pop3[c]));
      if (c > 0) begin
        chk("n3_bvalid", c, 32'(bvalid3), 32'd1);
        chk("n3_gidx",   c, 32'(gidx3),   32'(exp_g3[c]));
        chk("n3_bid",    c, 32'(bid3),    32'(exp_b3[c]));
      end
      $display("n3 cycle %0d pop=%b bvalid=%b bid=%h gidx=%0d", c, src_pop3, bvalid3, bid3, gidx3);
      @(posedge clk);
      #1;
    end
    src_empty3 = 3'b111;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
